// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller: the FSM
// state encoding, the stall vectors driven on `control`, and the bit
// positions of each pipeline stage within that vector.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MULTI = 2'd1,
        ST_FLUSH = 2'd2
    } stall_state_e;

    // Stall vectors. Each one holds a contiguous run of stages starting at PC,
    // so a deeper stall is always numerically larger than a shallower one.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // Bit positions within `control`.
    localparam int CTRL_PC  = 0;
    localparam int CTRL_IF  = 1;
    localparam int CTRL_ID  = 2;
    localparam int CTRL_EX  = 3;
    localparam int CTRL_MEM = 4;
    localparam int CTRL_WB  = 5;

    // Overlapping requests resolve to the deeper stall, which is the larger vector.
    function automatic logic [5:0] stall_max(input logic [5:0] a, input logic [5:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stall_perf_counters.sv
// Saturating performance counters for the stall controller: cycles spent
// with any stage held, and the number of exception flushes issued.
// Only instantiated when PIPE_STALL_PERF_EN is defined.
module stall_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_active,
    input  logic        flush_entry,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q,  flush_count_d;

    // Next-count: increment on each event, hold once all ones is reached.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_active && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush_entry && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: drives the 6-bit `control` hold vector to every
// stage register, sequences multi-cycle EX ops with a watchdog, and issues
// exception flushes with a redirect PC.
// Optional feature macro: PIPE_STALL_PERF_EN (performance counters).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal issue; load-use / memory-wait stalls only
// ST_MULTI | EX busy with div/mult; EX and earlier held until done
// ST_FLUSH | flush asserted for FLUSH_CYCLES; all requests ignored
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MULTI_MAX_CYCLES = 64,
    parameter int FLUSH_CYCLES     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_mem,
    input  logic        ex_multi_start,
    input  logic        ex_multi_done,
    input  logic        excp_valid,
    input  logic [31:0] excp_target,
    output logic [5:0]  control,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        ex_abort,
    output logic        multi_busy,
    output logic        timeout_err,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    // Last watchdog count before expiry, and flush down-counter load value.
    localparam logic [7:0] WD_LAST    = 8'(MULTI_MAX_CYCLES - 1);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    stall_state_e state_q, state_d;
    logic [7:0]   wd_cnt_q, wd_cnt_d;
    logic [1:0]   flush_cnt_q, flush_cnt_d;
    logic         flush_q, flush_d;
    logic [31:0]  new_pc_q, new_pc_d;
    logic         ex_abort_q, ex_abort_d;
    logic         timeout_err_q, timeout_err_d;
    logic [5:0]   control_c;

    // Next-state, watchdog, flush timer and redirect latch.
    always_comb begin
        state_d       = state_q;
        wd_cnt_d      = wd_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        new_pc_d      = new_pc_q;
        ex_abort_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_RUN: begin
                if (excp_valid) begin
                    new_pc_d    = excp_target;
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = ST_FLUSH;
                end else if (ex_multi_start) begin
                    wd_cnt_d = 8'd0;
                    state_d  = ST_MULTI;
                end
            end
            ST_MULTI: begin
                wd_cnt_d = wd_cnt_q + 8'd1;
                if (excp_valid) begin
                    ex_abort_d  = 1'b1;
                    new_pc_d    = excp_target;
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = ST_FLUSH;
                end else if (ex_multi_done) begin
                    state_d = ST_RUN;
                end else if (wd_cnt_q == WD_LAST) begin
                    timeout_err_d = 1'b1;
                    ex_abort_d    = 1'b1;
                    state_d       = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 2'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        flush_d = (state_d == ST_FLUSH);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            wd_cnt_q      <= 8'd0;
            flush_cnt_q   <= 2'd0;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'd0;
            ex_abort_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wd_cnt_q      <= wd_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
            ex_abort_q    <= ex_abort_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Stall vector: same-cycle from requests; the deepest request wins, nothing held while flushing.
    always_comb begin
        control_c = STALL_NONE;
        if (state_q != ST_FLUSH) begin
            if (stallreq_id) begin
                control_c = stall_max(control_c, STALL_ID);
            end
            if ((state_q == ST_MULTI) && !ex_multi_done) begin
                control_c = stall_max(control_c, STALL_EX);
            end
            if (stallreq_mem) begin
                control_c = stall_max(control_c, STALL_MEM);
            end
        end
    end

    assign control     = control_c;
    assign flush       = flush_q;
    assign new_pc      = new_pc_q;
    assign ex_abort    = ex_abort_q;
    assign multi_busy  = (state_q == ST_MULTI);
    assign timeout_err = timeout_err_q;

`ifdef PIPE_STALL_PERF_EN
    logic flush_entry;

    assign flush_entry = (state_q != ST_FLUSH) && (state_d == ST_FLUSH);

    stall_perf_counters u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_active (control_c != STALL_NONE),
        .flush_entry  (flush_entry),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 16'd0;
`endif

endmodule
